// File: rtl/display_select_ctrl.sv
// display_select_ctrl: debounced push-button cycling a registered 4-way display-word selector.
// Define DISPLAY_SELECT_AUTO_SCROLL_EN to add the auto_en port and timed auto-advance.
module display_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_raw,
    input  logic        hold,
`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
    input  logic        auto_en,
`endif
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    output logic [1:0]  state_show,
    output logic [31:0] disp_data,
    output logic        sel_changed
);

    typedef enum logic [1:0] {
        SelSrc0 = 2'b00,
        SelSrc1 = 2'b01,
        SelSrc2 = 2'b10,
        SelSrc3 = 2'b11
    } sel_e;

    localparam logic [15:0] DebLast = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_q;
    logic        deb_lvl_q, deb_lvl_d;
    logic        deb_prev_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        man_req;
    logic        auto_req;
    logic        advance;
    sel_e        sel_q, sel_d;
    logic [31:0] src_sel;
    logic        sel_changed_q;
    logic [31:0] disp_q;

    // Count consecutive synchronized samples that disagree with the accepted level.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = '0;
        if (sync_q[1] != deb_lvl_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_lvl_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    assign man_req = deb_lvl_q & ~deb_prev_q;

`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
    localparam logic [31:0] AutoLast = 32'(AUTO_PERIOD - 1);

    logic [31:0] auto_cnt_q, auto_cnt_d;

    assign auto_req = auto_en & ~hold & (auto_cnt_q == AutoLast);

    always_comb begin
        auto_cnt_d = auto_cnt_q + 32'd1;
        if (!auto_en) begin
            auto_cnt_d = '0;
        end else if (hold) begin
            auto_cnt_d = auto_cnt_q;
        end else if (auto_req || man_req) begin
            auto_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    assign auto_req = 1'b0;
`endif

    // Coincident manual and auto requests merge into a single step.
    assign advance = (man_req | auto_req) & ~hold;

    always_comb begin
        sel_d = sel_q;
        if (advance) begin
            unique case (sel_q)
                SelSrc0: sel_d = SelSrc1;
                SelSrc1: sel_d = SelSrc2;
                SelSrc2: sel_d = SelSrc3;
                SelSrc3: sel_d = SelSrc0;
                default: sel_d = SelSrc0;
            endcase
        end
    end

    always_comb begin
        src_sel = src0;
        unique case (sel_q)
            SelSrc0: src_sel = src0;
            SelSrc1: src_sel = src1;
            SelSrc2: src_sel = src2;
            SelSrc3: src_sel = src3;
            default: src_sel = src0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            deb_lvl_q     <= 1'b0;
            deb_prev_q    <= 1'b0;
            deb_cnt_q     <= '0;
            sel_q         <= SelSrc0;
            sel_changed_q <= 1'b0;
            disp_q        <= '0;
        end else begin
            sync_q        <= {sync_q[0], sw_raw};
            deb_lvl_q     <= deb_lvl_d;
            deb_prev_q    <= deb_lvl_q;
            deb_cnt_q     <= deb_cnt_d;
            sel_q         <= sel_d;
            sel_changed_q <= advance;
            disp_q        <= src_sel;
        end
    end

    assign state_show  = sel_q;
    assign disp_data   = disp_q;
    assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_display_select_ctrl.sv
// Bench for display_select_ctrl: cycle-level behavioural model plus directed press scenarios.
// Auto-scroll scenarios are exercised when DISPLAY_SELECT_AUTO_SCROLL_EN is defined.
module tb_display_select_ctrl;

    localparam int DEB = 4;
    localparam int AP  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sw_raw = 1'b0;
    logic        hold = 1'b0;
`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
    logic        auto_en = 1'b0;
`endif
    logic [31:0] src [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [1:0]  state_show;
    logic [31:0] disp_data;
    logic        sel_changed;

    display_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD    (AP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .hold       (hold),
`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
        .auto_en    (auto_en),
`endif
        .src0       (src[0]),
        .src1       (src[1]),
        .src2       (src[2]),
        .src3       (src[3]),
        .state_show (state_show),
        .disp_data  (disp_data),
        .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int npulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sample history, run length of disagreeing samples, selection as an integer mod 4.
    bit          h1, h2, lvl, lvl_prev, rise, areq, adv, exp_chg;
    int          run, msel, acnt;
    logic [31:0] exp_disp = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h1 = 0; h2 = 0; lvl = 0; lvl_prev = 0; run = 0; msel = 0; acnt = 0;
            exp_disp = '0; exp_chg = 0;
        end else begin
            rise = lvl && !lvl_prev;
            areq = 0;
`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
            areq = auto_en && !hold && (acnt == AP - 1);
            if (!auto_en) acnt = 0;
            else if (!hold) acnt = (areq || rise) ? 0 : acnt + 1;
`endif
            adv = (rise || areq) && !hold;
            exp_disp = src[msel];
            exp_chg = adv;
            if (adv) msel = (msel + 1) % 4;
            lvl_prev = lvl;
            if (h2 != lvl) begin
                run++;
                if (run == DEB) begin
                    lvl = h2;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            h2 = h1;
            h1 = sw_raw;
        end
    end

    always @(posedge clk) begin
        #1;
        check("state_show", 32'(state_show), 32'(msel));
        check("disp_data", disp_data, exp_disp);
        check("sel_changed", 32'(sel_changed), 32'(exp_chg));
        if (sel_changed === 1'b1) npulse++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        sw_raw = 1'b1;
        cycles(10);
        sw_raw = 1'b0;
        cycles(10);
    endtask

    int p0;

    initial begin
        cycles(3);
        check("reset_state", 32'(state_show), 32'd0);
        check("reset_disp", disp_data, 32'd0);
        check("reset_chg", 32'(sel_changed), 32'd0);
        rst_n = 1'b1;
        cycles(1);
        check("first_disp", disp_data, 32'h11111111);

        // Single clean press: advance on the 7th edge, disp follows one edge later.
        p0 = npulse;
        sw_raw = 1'b1;
        cycles(7);
        check("press_state", 32'(state_show), 32'd1);
        check("press_chg_hi", 32'(sel_changed), 32'd1);
        cycles(1);
        check("press_disp", disp_data, 32'h22222222);
        check("press_chg_lo", 32'(sel_changed), 32'd0);
        cycles(2);
        sw_raw = 1'b0;
        cycles(10);
        check("press_pulses", 32'(npulse - p0), 32'd1);

        // Bounce shorter than the debounce window is ignored.
        p0 = npulse;
        repeat (5) begin
            sw_raw = 1'b1;
            cycles(2);
            sw_raw = 1'b0;
            cycles(2);
        end
        cycles(10);
        check("bounce_state", 32'(state_show), 32'd1);
        check("bounce_pulses", 32'(npulse - p0), 32'd0);

        press();
        check("seq_state2", 32'(state_show), 32'd2);
        press();
        check("seq_state3", 32'(state_show), 32'd3);
        press();
        check("seq_wrap", 32'(state_show), 32'd0);
        check("seq_disp", disp_data, 32'h11111111);

        // Press during hold is dropped, not deferred.
        p0 = npulse;
        hold = 1'b1;
        press();
        check("hold_state", 32'(state_show), 32'd0);
        check("hold_pulses", 32'(npulse - p0), 32'd0);
        hold = 1'b0;
        cycles(10);
        check("hold_release", 32'(state_show), 32'd0);

        press();
        check("pre_reset_state", 32'(state_show), 32'd1);

        // Reset in mid-debounce (3 of 4 samples counted).
        sw_raw = 1'b1;
        cycles(5);
        rst_n = 1'b0;
        sw_raw = 1'b0;
        #1;
        check("mid_reset_state", 32'(state_show), 32'd0);
        check("mid_reset_disp", disp_data, 32'd0);
        check("mid_reset_chg", 32'(sel_changed), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        p0 = npulse;
        cycles(20);
        check("post_reset_state", 32'(state_show), 32'd0);
        check("post_reset_pulses", 32'(npulse - p0), 32'd0);

`ifdef DISPLAY_SELECT_AUTO_SCROLL_EN
        p0 = npulse;
        auto_en = 1'b1;
        cycles(40);
        check("auto_pulses", 32'(npulse - p0), 32'd5);
        check("auto_state", 32'(state_show), 32'd1);
        auto_en = 1'b0;
        cycles(3);
        // Manual rise aligned with the auto request: one step only, then counter restarts.
        auto_en = 1'b1;
        cycles(1);
        p0 = npulse;
        sw_raw = 1'b1;
        cycles(7);
        check("coincide_pulses", 32'(npulse - p0), 32'd1);
        check("coincide_state", 32'(state_show), 32'd2);
        cycles(7);
        check("restart_wait", 32'(npulse - p0), 32'd1);
        cycles(1);
        check("restart_next", 32'(npulse - p0), 32'd2);
        sw_raw = 1'b0;
        auto_en = 1'b0;
        cycles(10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
